// File: rtl/spi_xfer_sequencer_if.sv
// Bus bundle between the SPI register block / baud generator and the transfer sequencer.
// The sequencer binds to the master modport; the surrounding logic uses the slave modport.
interface spi_xfer_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              send_data_i;
    logic [DATA_W-1:0] data_tx_i;
    logic              lsbfe_i;
    logic              cphase_i;
    logic [1:0]        spi_mode_i;
    logic              spiswai_i;
    logic              mosi_send_sclk_i;
    logic              mosi_send_sclk0_i;
    logic              miso_receive_sclk_i;
    logic              miso_receive_sclk0_i;
    logic              miso_i;
    logic              ss_o;
    logic              mosi_o;
    logic              tip_o;
    logic [DATA_W-1:0] data_rx_o;
    logic              rx_valid_o;

    modport master (
        input  send_data_i, data_tx_i, lsbfe_i, cphase_i, spi_mode_i, spiswai_i,
               mosi_send_sclk_i, mosi_send_sclk0_i, miso_receive_sclk_i,
               miso_receive_sclk0_i, miso_i,
        output ss_o, mosi_o, tip_o, data_rx_o, rx_valid_o
    );

    modport slave (
        output send_data_i, data_tx_i, lsbfe_i, cphase_i, spi_mode_i, spiswai_i,
               mosi_send_sclk_i, mosi_send_sclk0_i, miso_receive_sclk_i,
               miso_receive_sclk0_i, miso_i,
        input  ss_o, mosi_o, tip_o, data_rx_o, rx_valid_o
    );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// SPI master frame sequencer: on a start request it enables the baud generator via ss_o,
// shifts one DATA_W-bit frame out/in on the generator strobes, then posts the received word.
module spi_xfer_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input logic                   PCLK,
    input logic                   PRESET,
    spi_xfer_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] data_rx;
    logic [CNT_W-1:0]  tx_cnt;
    logic [CNT_W-1:0]  rx_cnt;
    logic              lsbfe_q;
    logic              cphase_q;
    logic              ss;
    logic              mosi;
    logic              tip;
    logic              rx_valid;

    logic              stop;
    logic              frozen;
    logic              active;
    logic              send_stb;
    logic              recv_stb;
    logic [CNT_W-1:0]  tx_idx;
    logic              tx_bit;
    logic              first_bit;
    logic [DATA_W-1:0] rx_next;

    assign stop   = bus.spi_mode_i[1];
    assign frozen = (bus.spi_mode_i == 2'b01) && bus.spiswai_i;
    assign active = !stop && !frozen;

    // Strobe pair and bit order come from the values captured at frame start.
    assign send_stb  = cphase_q ? bus.mosi_send_sclk_i    : bus.mosi_send_sclk0_i;
    assign recv_stb  = cphase_q ? bus.miso_receive_sclk_i : bus.miso_receive_sclk0_i;
    assign tx_idx    = lsbfe_q ? tx_cnt : (LAST - tx_cnt);
    assign tx_bit    = |((tx_sr >> tx_idx) & DATA_W'(1));
    assign first_bit = bus.lsbfe_i ? bus.data_tx_i[0] : bus.data_tx_i[DATA_W-1];
    assign rx_next   = lsbfe_q ? {bus.miso_i, rx_sr[DATA_W-1:1]}
                               : {rx_sr[DATA_W-2:0], bus.miso_i};

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            tx_sr    <= '0;
            rx_sr    <= '0;
            data_rx  <= '0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            lsbfe_q  <= 1'b0;
            cphase_q <= 1'b0;
            ss       <= 1'b1;
            mosi     <= 1'b0;
            tip      <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.send_data_i && active) begin
                        state    <= LOAD;
                        tx_sr    <= bus.data_tx_i;
                        lsbfe_q  <= bus.lsbfe_i;
                        cphase_q <= bus.cphase_i;
                        ss       <= 1'b0;
                        tip      <= 1'b1;
                        rx_cnt   <= '0;
                        // Phase 0 needs the first bit on MOSI before the first sampling edge.
                        if (!bus.cphase_i) begin
                            mosi   <= first_bit;
                            tx_cnt <= CNT_W'(1);
                        end else begin
                            tx_cnt <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (stop) begin
                        state <= IDLE;
                        ss    <= 1'b1;
                        tip   <= 1'b0;
                    end else if (!frozen) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (stop) begin
                        state <= IDLE;
                        ss    <= 1'b1;
                        tip   <= 1'b0;
                    end else if (!frozen) begin
                        if (send_stb && (tx_cnt < FULL)) begin
                            mosi   <= tx_bit;
                            tx_cnt <= tx_cnt + CNT_W'(1);
                        end
                        if (recv_stb) begin
                            rx_sr  <= rx_next;
                            rx_cnt <= rx_cnt + CNT_W'(1);
                            if (rx_cnt == LAST) begin
                                state    <= DONE;
                                data_rx  <= rx_next;
                                rx_valid <= 1'b1;
                                ss       <= 1'b1;
                                tip      <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ss_o       = ss;
    assign bus.mosi_o     = mosi;
    assign bus.tip_o      = tip;
    assign bus.data_rx_o  = data_rx;
    assign bus.rx_valid_o = rx_valid;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed + randomized bench for spi_xfer_sequencer; the bench plays the baud generator and
// predicts MOSI bits and the received word from the frame rules (bit index arithmetic).
module tb_spi_xfer_sequencer;
    localparam int DW = 8;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_rx = '0;

    spi_xfer_sequencer_if #(.DATA_W(DW)) bus();

    spi_xfer_sequencer #(.DATA_W(DW), .CNT_W(4)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_bit(input logic [DW-1:0] d, input logic lsb, input int k);
        return lsb ? d[k] : d[DW-1-k];
    endfunction

    // One PCLK cycle with the selected strobe pair driven; the other pair carries random noise.
    task automatic strobes(input logic cph, input logic snd, input logic rcv, input bit noise);
        logic n1, n2;
        n1 = noise ? 1'($urandom) : 1'b0;
        n2 = noise ? 1'($urandom) : 1'b0;
        if (cph) begin
            bus.mosi_send_sclk_i     = snd;
            bus.miso_receive_sclk_i  = rcv;
            bus.mosi_send_sclk0_i    = n1;
            bus.miso_receive_sclk0_i = n2;
        end else begin
            bus.mosi_send_sclk0_i    = snd;
            bus.miso_receive_sclk0_i = rcv;
            bus.mosi_send_sclk_i     = n1;
            bus.miso_receive_sclk_i  = n2;
        end
        @(negedge PCLK);
    endtask

    task automatic gaps(input logic cph);
        repeat ($urandom % 3) strobes(cph, 1'b0, 1'b0, 1'b1);
    endtask

    // miso_mode: 0 loopback, 1 tied high, 2 random.  *_at = bit index for the event, -1 = none.
    task automatic frame(input logic [DW-1:0] d, input logic lsb, input logic cph,
                         input logic [1:0] mode, input logic swai, input int miso_mode,
                         input int freeze_at, input int abort_at, input int inject_at,
                         input int reset_at);
        logic [DW-1:0] rxw;
        logic          mb;
        logic          hold;
        rxw = '0;
        bus.spi_mode_i  = mode;
        bus.spiswai_i   = swai;
        bus.data_tx_i   = d;
        bus.lsbfe_i     = lsb;
        bus.cphase_i    = cph;
        bus.send_data_i = 1'b1;
        strobes(cph, 1'b0, 1'b0, 1'b0);
        bus.send_data_i = 1'b0;
        chk("load_ss", bus.ss_o, 0);
        chk("load_tip", bus.tip_o, 1);
        if (!cph) chk("load_mosi", bus.mosi_o, tx_bit(d, lsb, 0));
        bus.data_tx_i = DW'($urandom);
        bus.lsbfe_i   = 1'($urandom);
        bus.cphase_i  = 1'($urandom);
        strobes(cph, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < DW; k++) begin
            if (k == abort_at) begin
                bus.spi_mode_i = 2'b10 | 2'($urandom % 2);
                strobes(cph, 1'b1, 1'b1, 1'b1);
                chk("abort_ss", bus.ss_o, 1);
                chk("abort_tip", bus.tip_o, 0);
                chk("abort_vld", bus.rx_valid_o, 0);
                chk("abort_rx", bus.data_rx_o, exp_rx);
                bus.spi_mode_i = 2'b00;
                strobes(cph, 1'b0, 1'b0, 1'b0);
                chk("abort_vld2", bus.rx_valid_o, 0);
                chk("abort_ss2", bus.ss_o, 1);
                return;
            end
            if (k == reset_at) begin
                #2 PRESET = 1'b1;
                #1;
                chk("rst_ss", bus.ss_o, 1);
                chk("rst_mosi", bus.mosi_o, 0);
                chk("rst_rx", bus.data_rx_o, 0);
                chk("rst_tip", bus.tip_o, 0);
                chk("rst_vld", bus.rx_valid_o, 0);
                exp_rx = '0;
                @(negedge PCLK);
                PRESET = 1'b0;
                strobes(cph, 1'b0, 1'b0, 1'b0);
                chk("rst_idle_ss", bus.ss_o, 1);
                return;
            end
            if (k == freeze_at) begin
                hold = bus.mosi_o;
                bus.spi_mode_i = 2'b01;
                bus.spiswai_i  = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    bus.mosi_send_sclk_i     = 1'($urandom);
                    bus.mosi_send_sclk0_i    = 1'($urandom);
                    bus.miso_receive_sclk_i  = 1'($urandom);
                    bus.miso_receive_sclk0_i = 1'($urandom);
                    bus.miso_i               = 1'($urandom);
                    @(negedge PCLK);
                    chk("frz_ss", bus.ss_o, 0);
                    chk("frz_mosi", bus.mosi_o, hold);
                    chk("frz_vld", bus.rx_valid_o, 0);
                end
                bus.spi_mode_i = mode;
                bus.spiswai_i  = swai;
                strobes(cph, 1'b0, 1'b0, 1'b0);
                chk("frz_tip", bus.tip_o, 1);
            end
            if (cph) begin
                gaps(cph);
                strobes(cph, 1'b1, 1'b0, 1'b1);
                chk("mosi_c1", bus.mosi_o, tx_bit(d, lsb, k));
            end
            gaps(cph);
            if (k == inject_at) begin
                bus.send_data_i = 1'b1;
                bus.data_tx_i   = 8'h3C;
                strobes(cph, 1'b0, 1'b0, 1'b1);
                bus.send_data_i = 1'b0;
                chk("inj_tip", bus.tip_o, 1);
                chk("inj_ss", bus.ss_o, 0);
            end
            if (cph && k == DW - 1) begin
                strobes(cph, 1'b1, 1'b0, 1'b1);
                chk("mosi_extra", bus.mosi_o, tx_bit(d, lsb, DW - 1));
            end
            mb = (miso_mode == 0) ? bus.mosi_o : (miso_mode == 1) ? 1'b1 : 1'($urandom);
            bus.miso_i = mb;
            chk("shift_ss", bus.ss_o, 0);
            chk("shift_vld", bus.rx_valid_o, 0);
            strobes(cph, 1'b0, 1'b1, 1'b1);
            if (lsb) rxw[k] = mb;
            else     rxw[DW-1-k] = mb;
            if (!cph && k < DW - 1) begin
                gaps(cph);
                strobes(cph, 1'b1, 1'b0, 1'b1);
                chk("mosi_c0", bus.mosi_o, tx_bit(d, lsb, k + 1));
            end
        end
        chk("done_vld", bus.rx_valid_o, 1);
        chk("done_rx", bus.data_rx_o, rxw);
        chk("done_ss", bus.ss_o, 1);
        chk("done_tip", bus.tip_o, 0);
        exp_rx = rxw;
        strobes(cph, 1'b0, 1'b0, 1'b0);
        chk("post_vld", bus.rx_valid_o, 0);
        chk("post_rx", bus.data_rx_o, exp_rx);
        if (inject_at >= 0) begin
            repeat (3) begin
                strobes(cph, 1'b0, 1'b0, 1'b0);
                chk("inj_no_frame", bus.ss_o, 1);
            end
        end
    endtask

    initial begin
        bus.send_data_i = 1'b0;
        bus.data_tx_i = '0;
        bus.lsbfe_i = 1'b0;
        bus.cphase_i = 1'b0;
        bus.spi_mode_i = 2'b00;
        bus.spiswai_i = 1'b0;
        bus.mosi_send_sclk_i = 1'b0;
        bus.mosi_send_sclk0_i = 1'b0;
        bus.miso_receive_sclk_i = 1'b0;
        bus.miso_receive_sclk0_i = 1'b0;
        bus.miso_i = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("reset_ss", bus.ss_o, 1);
        chk("reset_mosi", bus.mosi_o, 0);
        chk("reset_tip", bus.tip_o, 0);
        chk("reset_rx", bus.data_rx_o, 0);
        chk("reset_vld", bus.rx_valid_o, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("idle_ss", bus.ss_o, 1);

        frame(8'hA5, 1'b0, 1'b0, 2'b00, 1'b0, 0, -1, -1, -1, -1);
        chk("a5_rx", bus.data_rx_o, 8'hA5);
        frame(8'h01, 1'b1, 1'b1, 2'b00, 1'b0, 1, -1, -1, -1, -1);
        chk("ones_rx", bus.data_rx_o, 8'hFF);
        frame(DW'($urandom), 1'($urandom), 1'($urandom), 2'b00, 1'b0, 2, 3, -1, -1, -1);
        frame(DW'($urandom), 1'($urandom), 1'($urandom), 2'b00, 1'b0, 2, -1, 4, -1, -1);
        frame(DW'($urandom), 1'($urandom), 1'($urandom), 2'b01, 1'b0, 0, -1, -1, 2, -1);

        for (int i = 0; i < 4; i++) begin
            bus.spi_mode_i  = (i < 2) ? 2'b10 | 2'(i) : 2'b01;
            bus.spiswai_i   = 1'b1;
            bus.send_data_i = 1'b1;
            @(negedge PCLK);
            bus.send_data_i = 1'b0;
            bus.spi_mode_i  = 2'b00;
            bus.spiswai_i   = 1'b0;
            @(negedge PCLK);
            chk("drop_ss", bus.ss_o, 1);
            chk("drop_tip", bus.tip_o, 0);
        end

        for (int i = 0; i < 10; i++) begin
            logic [1:0] m;
            m = 2'($urandom % 2);
            frame(DW'($urandom), 1'($urandom), 1'($urandom), m,
                  (m == 2'b00) ? 1'($urandom) : 1'b0, 2, -1, -1, -1, -1);
        end

        frame(8'h5A, 1'b0, 1'b0, 2'b00, 1'b0, 0, -1, -1, -1, -1);
        frame(8'hFF, 1'b0, 1'b1, 2'b00, 1'b0, 2, -1, -1, -1, 4);
        frame(DW'($urandom), 1'($urandom), 1'($urandom), 2'b00, 1'b0, 0, -1, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
